// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control constants, FSM state type and stall encoder.
// No ports; imported by the controller, its counter and its interface users.
package pipe_ctrl_pkg;
    localparam int          STALL_W   = 6;
    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_IF  = 6'b000011;
    localparam logic [5:0]  STALL_ID  = 6'b000111;
    localparam logic [5:0]  STALL_EX  = 6'b001111;
    localparam logic [5:0]  STALL_MEM = 6'b011111;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

    typedef enum logic {RUN, FLUSHED} state_e;

    // The deepest requesting stage freezes itself and everything upstream of it.
    function automatic logic [5:0] stall_encode(input logic if_r, input logic id_r,
                                                input logic ex_r, input logic mem_r);
        return mem_r ? STALL_MEM : ex_r ? STALL_EX : id_r ? STALL_ID : if_r ? STALL_IF : STALL_NONE;
    endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush bundle between the pipeline stages and pipe_ctrl.
// Requests: stallreq_from_{if,id,ex,mem}, excepttype_i, cp0_epc_i, stat_clr.
// Controls/status: stall[5:0], flush, new_pc, stall_cycles, flush_count, stall_timeout.
// master = controller side, slave = pipeline side.
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        stat_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;

    modport master (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i, stat_clr,
        output stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
    );
    modport slave (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i, stat_clr,
        input  stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; clr_i wins over inc_i.
// Ports: clk, rst (async, active-high), clr_i, inc_i, cnt_o[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: arbitrates stage stall requests, turns MEM exceptions into flush + redirect,
// and keeps stall/flush statistics with a consecutive-stall watchdog.
// Ports: clk, rst (async, active-high), bus (pipe_ctrl_if.master).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT    = 1024,
    parameter logic [31:0] EXC_HANDLER_ADDR = 32'h0000_0020
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_if.master    bus
);
    state_e      state_q, state_d;
    logic        exc_acc, stalled;
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        // FLUSHED masks the exception code MEM may still be holding, preventing a double flush.
        exc_acc   = rst != RstEnable && state_q == RUN && bus.excepttype_i != ZeroWord;
        state_d   = exc_acc ? FLUSHED : RUN;
        bus.flush = exc_acc;
        bus.new_pc = !exc_acc ? ZeroWord :
                     bus.excepttype_i == EXC_ERET ? bus.cp0_epc_i : EXC_HANDLER_ADDR;
        bus.stall = (rst == RstEnable || exc_acc) ? STALL_NONE :
                    stall_encode(bus.stallreq_from_if, bus.stallreq_from_id,
                                 bus.stallreq_from_ex, bus.stallreq_from_mem);
        stalled   = bus.stall != STALL_NONE;
        // Watchdog holds at the limit so the comparison below stays true without wrapping.
        wd_d      = (bus.stat_clr || !stalled || exc_acc) ? '0 :
                    wd_q == 32'(STALL_TIMEOUT) ? wd_q : wd_q + 32'd1;
        timeout_d = !bus.stat_clr && (timeout_q || wd_d == 32'(STALL_TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end

    assign bus.stall_timeout = timeout_q;

    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.stat_clr),
        .inc_i (stalled),
        .cnt_o (bus.stall_cycles)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.stat_clr),
        .inc_i (exc_acc),
        .cnt_o (bus.flush_count)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test-plan steps plus randomized traffic, checked every cycle
// against a behavioural model of the stall/flush rules and statistics.
module tb_pipe_ctrl;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.STALL_TIMEOUT(T), .EXC_HANDLER_ADDR(32'h0000_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model state: whether last cycle flushed, statistics, consecutive-stall run length.
    bit      m_flushed;
    longint  m_sc;
    int      m_fc;
    int      m_run;
    bit      m_to;

    function automatic logic exp_flush();
        return !rst && !m_flushed && bus.excepttype_i != 0;
    endfunction

    function automatic logic [5:0] exp_stall();
        if (rst || exp_flush()) return 6'b000000;
        if (bus.stallreq_from_mem) return 6'b011111;
        if (bus.stallreq_from_ex)  return 6'b001111;
        if (bus.stallreq_from_id)  return 6'b000111;
        if (bus.stallreq_from_if)  return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic logic [31:0] exp_new_pc();
        if (!exp_flush()) return 32'h0;
        return bus.excepttype_i == 32'he ? bus.cp0_epc_i : 32'h20;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flushed <= 1'b0;
            m_sc      <= 0;
            m_fc      <= 0;
            m_run     <= 0;
            m_to      <= 1'b0;
        end else begin
            automatic bit acc = exp_flush();
            automatic bit st  = exp_stall() != 0;
            automatic int nr  = (!st || acc) ? 0 : (m_run < T ? m_run + 1 : T);
            if (bus.stat_clr) begin
                m_sc  <= 0;
                m_fc  <= 0;
                m_run <= 0;
                m_to  <= 1'b0;
            end else begin
                if (st && m_sc < 64'hFFFF_FFFF) m_sc <= m_sc + 1;
                if (acc && m_fc < 65535) m_fc <= m_fc + 1;
                m_run <= nr;
                if (nr == T) m_to <= 1'b1;
            end
            m_flushed <= acc;
        end
    end

    always @(negedge clk) begin
        chk("stall",         32'(bus.stall),         32'(exp_stall()));
        chk("flush",         32'(bus.flush),         32'(exp_flush()));
        chk("new_pc",        bus.new_pc,             exp_new_pc());
        chk("stall_cycles",  bus.stall_cycles,       32'(m_sc));
        chk("flush_count",   32'(bus.flush_count),   32'(m_fc));
        chk("stall_timeout", 32'(bus.stall_timeout), 32'(m_to));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] codes [7];
    int burst = 0;
    bit gap   = 1'b0;

    initial begin
        bus.stallreq_from_if  = 0;
        bus.stallreq_from_id  = 0;
        bus.stallreq_from_ex  = 0;
        bus.stallreq_from_mem = 0;
        bus.excepttype_i      = 0;
        bus.cp0_epc_i         = 0;
        bus.stat_clr          = 0;
        #2;
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_sc",    bus.stall_cycles, 32'h0);
        tick();
        rst = 0;

        bus.stallreq_from_ex = 1;
        @(negedge clk); chk("ex_alone", 32'(bus.stall), 32'h0f); chk("ex_noflush", 32'(bus.flush), 32'h0);
        tick(); bus.stallreq_from_id = 1;
        @(negedge clk); chk("ex_id", 32'(bus.stall), 32'h0f);
        tick(); bus.stallreq_from_ex = 0; bus.stallreq_from_id = 0;
        @(negedge clk); chk("sc_two", bus.stall_cycles, 32'd2);
        tick();

        bus.excepttype_i = 32'h8;
        @(negedge clk); chk("exc8_flush", 32'(bus.flush), 32'h1); chk("exc8_pc", bus.new_pc, 32'h20);
        tick();
        @(negedge clk); chk("exc8_held_flush", 32'(bus.flush), 32'h0); chk("exc8_held_pc", bus.new_pc, 32'h0);
        tick(); bus.excepttype_i = 0;
        @(negedge clk); chk("exc8_fc", 32'(bus.flush_count), 32'd1);
        tick();

        bus.excepttype_i = 32'he; bus.cp0_epc_i = 32'h0000_1234;
        @(negedge clk); chk("eret_pc", bus.new_pc, 32'h0000_1234); chk("eret_flush", 32'(bus.flush), 32'h1);
        tick(); bus.excepttype_i = 0;
        tick();

        bus.stallreq_from_mem = 1; bus.excepttype_i = 32'hc;
        @(negedge clk);
        chk("memexc_stall", 32'(bus.stall), 32'h0);
        chk("memexc_flush", 32'(bus.flush), 32'h1);
        chk("memexc_pc",    bus.new_pc, 32'h20);
        tick(); bus.excepttype_i = 0;
        @(negedge clk); chk("flushed_mem_stall", 32'(bus.stall), 32'h1f);
        tick(); bus.stallreq_from_mem = 0;
        tick();

        bus.stat_clr = 1;
        tick(); bus.stat_clr = 0; bus.stallreq_from_id = 1;
        repeat (7) @(posedge clk);
        #1 chk("wd_before", 32'(bus.stall_timeout), 32'h0);
        tick(); chk("wd_set", 32'(bus.stall_timeout), 32'h1);
        bus.stallreq_from_id = 0;
        tick(); chk("wd_sticky", 32'(bus.stall_timeout), 32'h1); chk("wd_sc", bus.stall_cycles, 32'd8);
        bus.stat_clr = 1;
        tick(); bus.stat_clr = 0;
        chk("clr_to", 32'(bus.stall_timeout), 32'h0);
        chk("clr_sc", bus.stall_cycles, 32'h0);
        chk("clr_fc", 32'(bus.flush_count), 32'h0);

        bus.stallreq_from_id = 1;
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_sc", bus.stall_cycles, 32'd5);
        #2 rst = 1;
        #1;
        chk("async_rst_stall", 32'(bus.stall), 32'h0);
        chk("async_rst_sc",    bus.stall_cycles, 32'h0);
        tick(); rst = 0; bus.stallreq_from_id = 0; bus.excepttype_i = 32'h8;
        @(negedge clk); chk("post_rst_flush", 32'(bus.flush), 32'h1); chk("post_rst_pc", bus.new_pc, 32'h20);
        tick(); bus.excepttype_i = 0;
        @(negedge clk); chk("post_rst_fc", 32'(bus.flush_count), 32'd1);
        tick();

        codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h0};
        for (int i = 0; i < 4000; i++) begin
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(6, 14);
            bus.stallreq_from_if  = $urandom_range(0, 3) == 0;
            bus.stallreq_from_id  = burst > 0 || $urandom_range(0, 4) == 0;
            bus.stallreq_from_ex  = $urandom_range(0, 5) == 0;
            bus.stallreq_from_mem = $urandom_range(0, 7) == 0;
            if (burst > 0) begin
                burst--;
                bus.stallreq_from_ex  = 0;
                bus.stallreq_from_mem = 0;
            end
            bus.cp0_epc_i = $urandom;
            if (gap) begin
                bus.excepttype_i = 0;
                gap = 0;
            end else if (bus.excepttype_i != 0) begin
                gap = 1;
                if ($urandom_range(0, 1) == 1) bus.excepttype_i = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.excepttype_i = codes[$urandom_range(0, 6)];
                if (bus.excepttype_i == 0) bus.excepttype_i = $urandom | 32'h100;
            end
            bus.stat_clr = $urandom_range(0, 63) == 0;
            rst = $urandom_range(0, 399) == 0;
            tick();
        end
        rst = 0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller that drives the `stall[5:0]` and `flush` inputs consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb). It arbitrates stall requests from IF, ID, EX and MEM, and turns a MEM-stage exception into a flush plus a redirect PC. It also tracks stall statistics and runs a stall watchdog. It is the producer end of the stall/flush protocol that the pipeline registers obey.

## Interface
- `STALL_TIMEOUT`, default 1024: consecutive cycles with any `stall` bit set before `stall_timeout` is raised.
- `EXC_HANDLER_ADDR`, default 32'h0000_0020: redirect target for every exception except ERET.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high (`RstEnable`).
- `stallreq_from_if` in 1: IF needs to wait, e.g. an instruction bus wait.
- `stallreq_from_id` in 1: ID needs to wait, e.g. a load-use hazard.
- `stallreq_from_ex` in 1: EX needs to wait, e.g. a multi-cycle div/madd.
- `stallreq_from_mem` in 1: MEM needs to wait, e.g. a data bus wait.
- `excepttype_i` in 32: exception code from MEM. Zero means no exception.
- `cp0_epc_i` in 32: EPC value, already forwarded, used for ERET.
- `stat_clr` in 1: synchronous clear of the counters and the sticky timeout.
- `stall` out 6: stall vector. Bit 0 is PC, bits 1..5 are IF, ID, EX, MEM, WB.
- `flush` out 1: clears all pipeline registers this cycle.
- `new_pc` out 32: redirect address, valid while `flush`=1, otherwise zero.
- `stall_cycles` out 32: count of cycles with `stall`≠0.
- `flush_count` out 16: count of flushes taken.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- **Stall encoding** (combinational). The highest-priority active request wins:
  - MEM → 6'b011111
  - EX → 6'b001111
  - ID → 6'b000111
  - IF → 6'b000011
  - none → 6'b000000
- **Exception priority.** An accepted exception overrides all stalls: `stall`=0, `flush`=1.
- **new_pc decode** for an accepted exception:
  - 32'h0000_000e (ERET) → `cp0_epc_i`
  - 32'h0000_0001, 8, a, c, d and any other nonzero code → `EXC_HANDLER_ADDR`
- **FSM.** The state register is the only state besides the counters.
  - RUN: a nonzero `excepttype_i` is accepted, `flush`=1, and the next state is FLUSHED.
  - FLUSHED: lasts exactly one cycle. `excepttype_i` is ignored (`flush`=0), so an exception code still held by MEM cannot cause a double flush. Stall encoding is active as normal. Next state is always RUN.
- **stall_cycles.** Increments by 1 on every cycle with `stall`≠0. Saturates at 32'hFFFF_FFFF.
- **flush_count.** Increments on every accepted flush. Saturates at 16'hFFFF.
- **Watchdog counter.** Counts consecutive cycles with `stall`≠0. Cleared on any cycle with `stall`=0 or `flush`=1. When it reaches `STALL_TIMEOUT`, `stall_timeout` is set. The flag stays set until `stat_clr` or reset. The counter holds at `STALL_TIMEOUT` (no wrap).
- **stat_clr.** Zeroes `stall_cycles`, `flush_count`, the watchdog counter and `stall_timeout` at the next edge. If it coincides with an increment, the clear wins.
- **Reset.** `rst` forces state=RUN and all counters and flags to 0 immediately. While `rst` is high, `stall`=0, `flush`=0 and `new_pc`=0. Reset mid-stall or mid-FLUSHED returns to RUN with no pending flush.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the inputs and the current state. They take effect at the same edge the pipeline registers sample, with zero-cycle latency.
- Counters and the FSM update on the rising edge of `clk`. `stall_cycles` reflects the previous cycle's `stall`.
- `flush` is high for exactly one cycle per accepted exception, even if `excepttype_i` is held.
- An exception arriving together with `stallreq_from_mem` produces `flush`=1 and `stall`=0; the stall request is dropped for that cycle.
- `stall_timeout` rises on the edge where the consecutive-stall count reaches `STALL_TIMEOUT`.

## Structure
- The shared defines header gets:
  - the stall vector widths and encodings (`STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`);
  - the exception code constants, including `EXC_ERET`=32'h0000_000e;
  - the existing `Stop`/`NoStop`, `RstEnable` and `ZeroWord`.
- One natural sub-module: `sat_counter`, a parameterised-width saturating counter with clear. It is used for both statistics counters.

## Test plan
- `stallreq_from_ex`=1 alone → `stall`=6'b001111 and `flush`=0. Add `stallreq_from_id`=1 → still 6'b001111.
- `excepttype_i`=32'h8 held 3 cycles → `flush`=1 only in the first cycle, `new_pc`=32'h20 that cycle, `flush_count`=1.
- `excepttype_i`=32'he with `cp0_epc_i`=32'h0000_1234 → `new_pc`=32'h0000_1234 and `flush`=1.
- `stallreq_from_mem`=1 together with `excepttype_i`=32'hc → `stall`=0, `flush`=1, `new_pc`=32'h20.
- `STALL_TIMEOUT`=8 with `stallreq_from_id` held 8 cycles → `stall_timeout`=1 after the 8th edge, and it stays 1 after the request drops. Pulse `stat_clr` → flag and counters become 0.
- Assert `rst` asynchronously mid-stall with `stall_cycles`=5 → all outputs go to 0 immediately. After release, the FSM is in RUN and the first exception flushes normally.
